unified_mem_arbiter: RTL and testbench
======================================

Name: unified_mem_arbiter

Overview:
- Shares one single-port unified memory between the core's instruction-fetch requester and data (load/store) requester.
- Sits between the pipelined RISC-V core and the memory model, replacing separate instruction and data memories.
- Runs one transaction at a time through a 3-state FSM.
- Data side has fixed priority; a starvation counter guarantees fetch progress.

Parameters:
- DATA_WIDTH, 32, width of addresses and data words.
- STARVE_LIMIT, 4, number of consecutive data grants made while fetch waits before fetch is forced to win; legal range 1..15.

Ports:
- clk  in  1  clock, rising edge.
- reset  in  1  asynchronous, active-low reset (0 = reset).
- i_req  in  1  fetch request; held until i_gnt.
- i_addr  in  DATA_WIDTH  fetch address.
- i_gnt  out  1  fetch request captured (1-cycle pulse).
- i_rvalid  out  1  fetch data valid (1-cycle pulse).
- i_rdata  out  DATA_WIDTH  fetch data.
- d_req  in  1  data request; held until d_gnt.
- d_we  in  1  1 = store, 0 = load.
- d_addr  in  DATA_WIDTH  data address.
- d_wdata  in  DATA_WIDTH  store data.
- d_gnt  out  1  data request captured (1-cycle pulse).
- d_rvalid  out  1  load data valid or store complete (1-cycle pulse).
- d_rdata  out  DATA_WIDTH  load data.
- m_req  out  1  memory request.
- m_we  out  1  memory write enable.
- m_addr  out  DATA_WIDTH  memory address.
- m_wdata  out  DATA_WIDTH  memory write data.
- m_ready  in  1  memory accepts the request this cycle.
- m_rvalid  in  1  memory response valid; asserted for both reads and writes.
- m_rdata  in  DATA_WIDTH  memory read data.

Behaviour:
- Reset (reset=0, asynchronous):
  - FSM goes to IDLE; starve_cnt=0; owner=data.
  - All outputs are 0, including all data and address buses.
  - Any in-flight transaction is abandoned; a late m_rvalid after reset release while in IDLE is ignored.
- States: IDLE, REQ, RESP.
- IDLE:
  - With no request: stay in IDLE.
  - With a request: arbitrate combinationally.
    - Fetch wins if i_req && (!d_req || starve_cnt==STARVE_LIMIT).
    - Otherwise data wins.
  - In the same cycle: the winner's gnt is 1 (combinational); address, we and wdata are latched (we=0 for fetch) along with the owner; go to REQ.
  - The loser's gnt is 0; it must keep its req asserted.
- starve_cnt, updated on each grant:
  - Fetch granted: starve_cnt=0.
  - Data granted while i_req=1: starve_cnt increments, saturating at STARVE_LIMIT.
  - Data granted while i_req=0: starve_cnt unchanged.
- REQ:
  - m_req=1 with the latched m_addr/m_we/m_wdata, held stable until m_ready.
  - On m_ready=1, go to RESP; m_req falls in the next cycle.
- RESP:
  - m_req=0; wait for m_rvalid.
  - On m_rvalid=1:
    - Register m_rdata into the owner's rdata.
    - Pulse the owner's rvalid for exactly one cycle, in the cycle after m_rvalid.
    - Go to IDLE.
  - The non-owner's rvalid stays 0 and its rdata holds its last value.
  - For a store, d_rvalid still pulses; d_rdata is loaded with m_rdata (don't-care content).
- Ignored inputs:
  - m_ready outside REQ.
  - m_rvalid outside RESP; m_rvalid in the same cycle as m_ready is not accepted.
  - Any change in requester inputs after its gnt.
- Minimum latency with a zero-wait memory (m_ready=1 and m_rvalid in the cycle after acceptance):
  - gnt at T, m_req at T+1, m_rvalid at T+2, x_rvalid at T+3.
  - IDLE is re-entered at T+3, so the next gnt can occur at T+3.
  - Throughput: one transaction per 3 cycles.
- Simultaneous events:
  - Both requests in IDLE: data wins unless starve_cnt==STARVE_LIMIT.
  - A requester may assert a new req in the same cycle its rvalid pulses; it is arbitrated normally that cycle.
- No combinational path from m_* inputs to i_*/d_* outputs. The only combinational outputs are i_gnt/d_gnt, from the req inputs and state.

Test Plan:
1. Single fetch: i_req=1, i_addr=0x10; memory returns 0x00100093 one cycle after m_ready. -> i_gnt at T; m_req=1 with m_addr=0x10, m_we=0 at T+1; i_rvalid=1 with i_rdata=0x00100093 at T+3; d_rvalid stays 0.
2. Store then load: d_req, d_we=1, d_addr=0x40, d_wdata=0xFFFFFFFE; then load from 0x40. -> m_we=1 with m_wdata=0xFFFFFFFE on the store; d_rvalid pulses twice; the second d_rdata=0xFFFFFFFE.
3. Contention and starvation (STARVE_LIMIT=4): d_req and i_req held high continuously. -> grant order is D,D,D,D,I,D,D,D,D,I; starve_cnt returns to 0 after each fetch grant.
4. Memory wait states: m_ready low for 3 cycles in REQ, then m_rvalid delayed 2 cycles in RESP. -> m_req and m_addr stay stable for all 4 REQ cycles; exactly one rvalid pulse; no second grant until IDLE.
5. Reset mid-transaction: reset=0 asynchronously while in RESP, m_rvalid=1 shortly after release. -> all outputs 0 immediately; no i_rvalid/d_rvalid pulse; the next request is serviced normally.
6. Spurious inputs: m_rvalid=1 in IDLE and m_ready=1 in RESP. -> no state change, no rvalid pulse.

Source files
------------

// File: rtl/unified_mem_arbiter.sv
// rtl/unified_mem_arbiter.sv - single-port memory arbiter shared by fetch and load/store requesters
module unified_mem_arbiter #(
  parameter int DATA_WIDTH   = 32,
  parameter int STARVE_LIMIT = 4
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  i_req,
  input  logic [DATA_WIDTH-1:0] i_addr,
  output logic                  i_gnt,
  output logic                  i_rvalid,
  output logic [DATA_WIDTH-1:0] i_rdata,
  input  logic                  d_req,
  input  logic                  d_we,
  input  logic [DATA_WIDTH-1:0] d_addr,
  input  logic [DATA_WIDTH-1:0] d_wdata,
  output logic                  d_gnt,
  output logic                  d_rvalid,
  output logic [DATA_WIDTH-1:0] d_rdata,
  output logic                  m_req,
  output logic                  m_we,
  output logic [DATA_WIDTH-1:0] m_addr,
  output logic [DATA_WIDTH-1:0] m_wdata,
  input  logic                  m_ready,
  input  logic                  m_rvalid,
  input  logic [DATA_WIDTH-1:0] m_rdata
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    RESP = 2'd2
  } state_t;

  localparam logic [3:0] LIMIT = 4'(STARVE_LIMIT);

  state_t     state;
  state_t     state_nxt;
  logic       owner_fetch;
  logic [3:0] starve_cnt;
  logic       fetch_wins;

  // Fetch takes the memory when data is idle or data has starved it long enough
  always_comb begin
    fetch_wins = i_req && (!d_req || (starve_cnt == LIMIT));
  end

  // Next-state and combinational grants; grants are held low while reset is asserted
  always_comb begin
    state_nxt = state;
    i_gnt     = 1'b0;
    d_gnt     = 1'b0;
    case (state)
      IDLE: begin
        if (reset) begin
          if (fetch_wins) begin
            i_gnt     = 1'b1;
            state_nxt = REQ;
          end else if (d_req) begin
            d_gnt     = 1'b1;
            state_nxt = REQ;
          end
        end
      end
      REQ: begin
        if (m_ready) begin
          state_nxt = RESP;
        end
      end
      RESP: begin
        if (m_rvalid) begin
          state_nxt = IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  // State register
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // The memory request is simply the REQ state; address and data come from the grant latch
  always_comb begin
    m_req = (state == REQ);
  end

  // Grant latch, starvation counter and registered response routing
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      owner_fetch <= 1'b0;
      starve_cnt  <= 4'd0;
      m_addr      <= '0;
      m_we        <= 1'b0;
      m_wdata     <= '0;
      i_rdata     <= '0;
      d_rdata     <= '0;
      i_rvalid    <= 1'b0;
      d_rvalid    <= 1'b0;
    end else begin
      i_rvalid <= 1'b0;
      d_rvalid <= 1'b0;
      if (i_gnt) begin
        owner_fetch <= 1'b1;
        m_addr      <= i_addr;
        m_we        <= 1'b0;
        m_wdata     <= '0;
        starve_cnt  <= 4'd0;
      end else if (d_gnt) begin
        owner_fetch <= 1'b0;
        m_addr      <= d_addr;
        m_we        <= d_we;
        m_wdata     <= d_wdata;
        // Only count data wins that actually kept a waiting fetch out
        if (i_req && (starve_cnt != LIMIT)) begin
          starve_cnt <= starve_cnt + 4'd1;
        end
      end
      if ((state == RESP) && m_rvalid) begin
        if (owner_fetch) begin
          i_rdata  <= m_rdata;
          i_rvalid <= 1'b1;
        end else begin
          d_rdata  <= m_rdata;
          d_rvalid <= 1'b1;
        end
      end
    end
  end

endmodule

// File: tb/tb_unified_mem_arbiter.sv
// tb/tb_unified_mem_arbiter.sv - scoreboard bench for unified_mem_arbiter
module tb_unified_mem_arbiter;

  localparam int DW = 32;

  logic          clk = 1'b0;
  logic          reset;
  logic          i_req, i_gnt, i_rvalid;
  logic [DW-1:0] i_addr, i_rdata;
  logic          d_req, d_we, d_gnt, d_rvalid;
  logic [DW-1:0] d_addr, d_wdata, d_rdata;
  logic          m_req, m_we, m_ready, m_rvalid;
  logic [DW-1:0] m_addr, m_wdata, m_rdata;

  always #5 clk = ~clk;

  unified_mem_arbiter #(.DATA_WIDTH(DW), .STARVE_LIMIT(4)) dut (
    .clk(clk), .reset(reset),
    .i_req(i_req), .i_addr(i_addr), .i_gnt(i_gnt), .i_rvalid(i_rvalid), .i_rdata(i_rdata),
    .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata),
    .d_gnt(d_gnt), .d_rvalid(d_rvalid), .d_rdata(d_rdata),
    .m_req(m_req), .m_we(m_we), .m_addr(m_addr), .m_wdata(m_wdata),
    .m_ready(m_ready), .m_rvalid(m_rvalid), .m_rdata(m_rdata)
  );

  int checks   = 0;
  int failures = 0;

  typedef struct {
    bit            chk;
    logic [DW-1:0] data;
  } exp_t;

  exp_t          i_q[$];
  exp_t          d_q[$];
  byte           gq[$];
  logic [DW-1:0] ref_mem[logic [DW-1:0]];
  logic [DW-1:0] mem[logic [DW-1:0]];

  bit            mem_manual = 1'b0;
  logic          man_ready  = 1'b0;
  logic          man_rvalid = 1'b0;
  logic [DW-1:0] man_rdata  = '0;
  int            ready_wait = 0;
  int            resp_wait  = 0;
  int            wait_cnt   = 0;
  int            resp_cnt   = 0;
  bit            resp_pending = 1'b0;
  logic [DW-1:0] resp_data  = '0;

  function automatic logic [DW-1:0] dflt(input logic [DW-1:0] a);
    return {a[15:0], 16'hC0DE};
  endfunction

  function automatic logic [DW-1:0] ref_read(input logic [DW-1:0] a);
    return ref_mem.exists(a) ? ref_mem[a] : dflt(a);
  endfunction

  function automatic logic [DW-1:0] mem_read(input logic [DW-1:0] a);
    return mem.exists(a) ? mem[a] : dflt(a);
  endfunction

  // Memory model: optional wait states before accept and before response
  always @(negedge clk) begin
    if (mem_manual) begin
      m_ready  = man_ready;
      m_rvalid = man_rvalid;
      m_rdata  = man_rdata;
    end else begin
      m_ready  = 1'b0;
      m_rvalid = 1'b0;
      if (resp_pending) begin
        if (resp_cnt == 0) begin
          m_rvalid     = 1'b1;
          m_rdata      = resp_data;
          resp_pending = 1'b0;
        end else begin
          resp_cnt--;
        end
      end else if (m_req) begin
        if (wait_cnt < ready_wait) begin
          wait_cnt++;
        end else begin
          m_ready  = 1'b1;
          wait_cnt = 0;
          if (m_we) mem[m_addr] = m_wdata;
          resp_data    = m_we ? 32'h0 : mem_read(m_addr);
          resp_pending = 1'b1;
          resp_cnt     = resp_wait;
        end
      end
    end
  end

  // Scoreboard: push expectations on grants, pop and compare on rvalid pulses
  always @(negedge clk) begin
    exp_t e;
    if (reset) begin
      if (i_rvalid) begin
        checks++;
        if (i_q.size() == 0) begin
          failures++;
          $display("FAIL i_rvalid_unexpected got=1 want=0");
        end else begin
          e = i_q.pop_front();
          if (e.chk && (i_rdata !== e.data)) begin
            failures++;
            $display("FAIL i_rdata got=%h want=%h", i_rdata, e.data);
          end
        end
      end
      if (d_rvalid) begin
        checks++;
        if (d_q.size() == 0) begin
          failures++;
          $display("FAIL d_rvalid_unexpected got=1 want=0");
        end else begin
          e = d_q.pop_front();
          if (e.chk && (d_rdata !== e.data)) begin
            failures++;
            $display("FAIL d_rdata got=%h want=%h", d_rdata, e.data);
          end
        end
      end
      if (i_gnt || d_gnt) begin
        checks++;
        if (i_gnt && d_gnt) begin
          failures++;
          $display("FAIL gnt_exclusive got=both want=one");
        end
      end
      if (i_gnt) begin
        gq.push_back("I");
        i_q.push_back('{1'b1, ref_read(i_addr)});
      end
      if (d_gnt) begin
        gq.push_back("D");
        if (d_we) begin
          ref_mem[d_addr] = d_wdata;
          d_q.push_back('{1'b0, 32'h0});
        end else begin
          d_q.push_back('{1'b1, ref_read(d_addr)});
        end
      end
    end
  end

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic wait_gnt(input bit is_i, output int lat);
    lat = -1;
    for (int n = 0; n < 60; n++) begin
      @(negedge clk);
      if (is_i ? i_gnt : d_gnt) begin
        lat = n;
        break;
      end
    end
    checks++;
    if (lat < 0) begin
      failures++;
      $display("FAIL gnt_timeout is_fetch=%0d got=none want=gnt", is_i);
    end
  endtask

  task automatic drain;
    bit done = 1'b0;
    for (int n = 0; n < 100; n++) begin
      @(negedge clk);
      if (i_q.size() == 0 && d_q.size() == 0 && !resp_pending && !m_req) begin
        done = 1'b1;
        break;
      end
    end
    checks++;
    if (!done) begin
      failures++;
      $display("FAIL drain_timeout got=pending i=%0d d=%0d want=empty", i_q.size(), d_q.size());
    end
    tick;
  endtask

  task automatic test_reset;
    reset = 1'b0;
    i_req = 1'b1; i_addr = 32'h10;
    d_req = 1'b1; d_we = 1'b1; d_addr = 32'h40; d_wdata = 32'hFFFF_FFFF;
    repeat (3) @(negedge clk);
    checks++;
    if ({i_gnt, d_gnt, i_rvalid, d_rvalid, m_req, m_we} !== 6'b0 ||
        i_rdata !== 32'h0 || d_rdata !== 32'h0 || m_addr !== 32'h0 || m_wdata !== 32'h0) begin
      failures++;
      $display("FAIL reset_outputs got=gnt%b%b rv%b%b mreq%b we%b ma=%h mw=%h ir=%h dr=%h want=all0",
               i_gnt, d_gnt, i_rvalid, d_rvalid, m_req, m_we, m_addr, m_wdata, i_rdata, d_rdata);
    end
    i_req = 1'b0; d_req = 1'b0; d_we = 1'b0; d_addr = '0; d_wdata = '0; i_addr = '0;
    tick;
    reset = 1'b1;
    tick;
  endtask

  task automatic test_single_fetch;
    int lat;
    tick;
    i_req = 1'b1; i_addr = 32'h10;
    wait_gnt(1'b1, lat);
    checks++;
    if (lat != 0) begin
      failures++;
      $display("FAIL fetch_gnt_latency got=%0d want=0", lat);
    end
    tick;
    i_req = 1'b0;
    @(negedge clk);
    checks++;
    if (m_req !== 1'b1 || m_addr !== 32'h10 || m_we !== 1'b0) begin
      failures++;
      $display("FAIL fetch_mreq got=req%b addr=%h we%b want=req1 addr=10 we0", m_req, m_addr, m_we);
    end
    @(negedge clk);
    checks++;
    if (i_rvalid !== 1'b0) begin
      failures++;
      $display("FAIL fetch_rvalid_early got=%b want=0", i_rvalid);
    end
    @(negedge clk);
    checks++;
    if (i_rvalid !== 1'b1 || i_rdata !== 32'h0010_0093 || d_rvalid !== 1'b0) begin
      failures++;
      $display("FAIL fetch_resp got=rv%b data=%h drv%b want=rv1 data=00100093 drv0",
               i_rvalid, i_rdata, d_rvalid);
    end
    drain;
  endtask

  task automatic test_store_load;
    int lat;
    int pulses = 0;
    tick;
    d_req = 1'b1; d_we = 1'b1; d_addr = 32'h40; d_wdata = 32'hFFFF_FFFE;
    wait_gnt(1'b0, lat);
    tick;
    d_req = 1'b0; d_wdata = 32'h0;
    @(negedge clk);
    checks++;
    if (m_req !== 1'b1 || m_we !== 1'b1 || m_wdata !== 32'hFFFF_FFFE || m_addr !== 32'h40) begin
      failures++;
      $display("FAIL store_mreq got=req%b we%b wd=%h a=%h want=req1 we1 wd=fffffffe a=40",
               m_req, m_we, m_wdata, m_addr);
    end
    repeat (6) begin
      @(negedge clk);
      if (d_rvalid) pulses++;
    end
    tick;
    d_req = 1'b1; d_we = 1'b0; d_addr = 32'h40;
    wait_gnt(1'b0, lat);
    tick;
    d_req = 1'b0;
    repeat (6) begin
      @(negedge clk);
      if (d_rvalid) pulses++;
    end
    checks++;
    if (pulses != 2) begin
      failures++;
      $display("FAIL store_load_pulses got=%0d want=2", pulses);
    end
    checks++;
    if (d_rdata !== 32'hFFFF_FFFE || i_rvalid !== 1'b0) begin
      failures++;
      $display("FAIL load_data got=%h irv%b want=fffffffe irv0", d_rdata, i_rvalid);
    end
    drain;
  endtask

  task automatic test_starvation;
    string exp_order = "DDDDIDDDDI";
    bit got10 = 1'b0;
    reset = 1'b0;
    tick;
    reset = 1'b1;
    gq.delete();
    i_req = 1'b1; i_addr = 32'h100;
    d_req = 1'b1; d_we = 1'b0; d_addr = 32'h200;
    for (int n = 0; n < 200; n++) begin
      @(negedge clk);
      if (gq.size() >= 10) begin
        got10 = 1'b1;
        break;
      end
    end
    tick;
    i_req = 1'b0; d_req = 1'b0;
    checks++;
    if (!got10) begin
      failures++;
      $display("FAIL starve_grants got=%0d want=10", gq.size());
    end else begin
      for (int k = 0; k < 10; k++) begin
        checks++;
        if (gq[k] != exp_order[k]) begin
          failures++;
          $display("FAIL starve_order idx=%0d got=%s want=%s", k, gq[k], exp_order[k]);
        end
      end
    end
    drain;
  endtask

  task automatic test_wait_states;
    int lat;
    ready_wait = 3;
    resp_wait  = 2;
    tick;
    i_req = 1'b1; i_addr = 32'h20;
    wait_gnt(1'b1, lat);
    tick;
    i_req = 1'b0;
    d_req = 1'b1; d_we = 1'b0; d_addr = 32'h40;
    for (int k = 1; k <= 8; k++) begin
      @(negedge clk);
      checks++;
      if (m_req !== (k <= 4) || (k <= 4 && m_addr !== 32'h20) ||
          d_gnt !== (k == 8) || i_rvalid !== (k == 8)) begin
        failures++;
        $display("FAIL wait_states k=%0d got=req%b a=%h dgnt%b irv%b want=req%0d a=20 dgnt%0d irv%0d",
                 k, m_req, m_addr, d_gnt, i_rvalid, k <= 4, k == 8, k == 8);
      end
    end
    tick;
    d_req = 1'b0;
    drain;
    ready_wait = 0;
    resp_wait  = 0;
  endtask

  task automatic test_reset_mid;
    int lat;
    resp_wait = 6;
    tick;
    i_req = 1'b1; i_addr = 32'h10;
    wait_gnt(1'b1, lat);
    tick;
    i_req = 1'b0;
    @(negedge clk);
    @(negedge clk);
    reset = 1'b0;
    #1;
    checks++;
    if ({i_gnt, d_gnt, i_rvalid, d_rvalid, m_req, m_we} !== 6'b0 ||
        i_rdata !== 32'h0 || d_rdata !== 32'h0 || m_addr !== 32'h0 || m_wdata !== 32'h0) begin
      failures++;
      $display("FAIL reset_mid_outputs got=rv%b%b mreq%b ma=%h ir=%h dr=%h want=all0",
               i_rvalid, d_rvalid, m_req, m_addr, i_rdata, d_rdata);
    end
    i_q.delete();
    d_q.delete();
    tick;
    reset = 1'b1;
    for (int k = 0; k < 10; k++) begin
      @(negedge clk);
      checks++;
      if (i_rvalid !== 1'b0 || d_rvalid !== 1'b0 || m_req !== 1'b0) begin
        failures++;
        $display("FAIL reset_late_rvalid k=%0d got=irv%b drv%b mreq%b want=0", k, i_rvalid, d_rvalid, m_req);
      end
    end
    resp_wait = 0;
    tick;
    i_req = 1'b1; i_addr = 32'h40;
    wait_gnt(1'b1, lat);
    tick;
    i_req = 1'b0;
    drain;
    checks++;
    if (i_rdata !== 32'hFFFF_FFFE) begin
      failures++;
      $display("FAIL reset_recover got=%h want=fffffffe", i_rdata);
    end
  endtask

  task automatic test_spurious;
    int lat;
    man_ready = 1'b0; man_rvalid = 1'b0; man_rdata = '0;
    mem_manual = 1'b1;
    tick;
    man_ready = 1'b1; man_rvalid = 1'b1; man_rdata = 32'hDEAD_BEEF;
    tick;
    man_ready = 1'b0; man_rvalid = 1'b0;
    @(negedge clk);
    checks++;
    if (i_rvalid !== 1'b0 || d_rvalid !== 1'b0 || m_req !== 1'b0) begin
      failures++;
      $display("FAIL idle_spurious got=irv%b drv%b mreq%b want=0", i_rvalid, d_rvalid, m_req);
    end
    tick;
    @(negedge clk);
    checks++;
    if (i_rdata !== 32'hFFFF_FFFE || d_rdata !== 32'h0) begin
      failures++;
      $display("FAIL idle_spurious_data got=ir=%h dr=%h want=fffffffe 0", i_rdata, d_rdata);
    end
    tick;
    i_req = 1'b1; i_addr = 32'h10;
    wait_gnt(1'b1, lat);
    checks++;
    if (lat != 0) begin
      failures++;
      $display("FAIL spurious_gnt_latency got=%0d want=0", lat);
    end
    tick;
    i_req = 1'b0;
    @(negedge clk);
    checks++;
    if (m_req !== 1'b1) begin
      failures++;
      $display("FAIL spurious_req got=%b want=1", m_req);
    end
    tick;
    man_ready = 1'b1; man_rvalid = 1'b1; man_rdata = 32'hDEAD_BEEF;
    tick;
    man_ready = 1'b1; man_rvalid = 1'b0;
    @(negedge clk);
    checks++;
    if (m_req !== 1'b0 || i_rvalid !== 1'b0) begin
      failures++;
      $display("FAIL rvalid_with_ready got=mreq%b irv%b want=0 0", m_req, i_rvalid);
    end
    tick;
    man_ready = 1'b0;
    @(negedge clk);
    checks++;
    if (i_rvalid !== 1'b0 || m_req !== 1'b0) begin
      failures++;
      $display("FAIL ready_in_resp got=irv%b mreq%b want=0 0", i_rvalid, m_req);
    end
    tick;
    man_rvalid = 1'b1; man_rdata = 32'h0010_0093;
    tick;
    man_rvalid = 1'b0;
    @(negedge clk);
    checks++;
    if (i_rvalid !== 1'b1 || i_rdata !== 32'h0010_0093) begin
      failures++;
      $display("FAIL spurious_resp got=irv%b data=%h want=1 00100093", i_rvalid, i_rdata);
    end
    tick;
    @(negedge clk);
    checks++;
    if (i_rvalid !== 1'b0) begin
      failures++;
      $display("FAIL spurious_single_pulse got=%b want=0", i_rvalid);
    end
    mem_manual = 1'b0;
    drain;
  endtask

  initial begin
    reset = 1'b0;
    i_req = 1'b0; i_addr = '0;
    d_req = 1'b0; d_we = 1'b0; d_addr = '0; d_wdata = '0;
    m_ready = 1'b0; m_rvalid = 1'b0; m_rdata = '0;
    mem[32'h10]     = 32'h0010_0093;
    ref_mem[32'h10] = 32'h0010_0093;
    test_reset();
    test_single_fetch();
    test_store_load();
    test_starvation();
    test_wait_states();
    test_reset_mid();
    test_spurious();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL global_timeout got=running want=finished");
    $fatal(1, "timeout");
  end

endmodule
